// File: rtl/sgmii_tx_ordered_set_gen.sv
// sgmii_tx_ordered_set_gen
// Transmit-side PCS ordered-set generator for the SGMII core. Turns the
// byte-wide GMII-style TxEN/TxER/TxD stream into octet + K-flag code-groups:
// /I/ idles, /C/ autoneg config sets, and /S/ data /T/ /R/ frames, with /V/
// replacing errored bytes. Every output is registered, so an input seen in
// one cycle shapes the code-group presented in the next.
module sgmii_tx_ordered_set_gen #(
  parameter int pIdleMinSets = 1
) (
  input  logic        i_Clk,
  input  logic        i_ARst_L,
  input  logic [1:0]  i2_Xmit,
  input  logic [15:0] i16_ConfigReg,
  input  logic        i_TxEN,
  input  logic        i_TxER,
  input  logic [7:0]  i8_TxD,
  input  logic        i_RdPos,
  output logic [7:0]  o8_Data,
  output logic        o_Kchar,
  output logic        o_Even
);

  // State encodes the code-group the next clock edge will emit.
  localparam logic [2:0] sIdleK = 3'd0;
  localparam logic [2:0] sIdleD = 3'd1;
  localparam logic [2:0] sCfg   = 3'd2;
  localparam logic [2:0] sData  = 3'd3;
  localparam logic [2:0] sEopR1 = 3'd4;
  localparam logic [2:0] sEopR2 = 3'd5;

  localparam logic [1:0] xIdle   = 2'b00;
  localparam logic [1:0] xConfig = 2'b01;
  localparam logic [1:0] xData   = 2'b10;

  localparam logic [7:0] cK28p5 = 8'hBC;
  localparam logic [7:0] cSop   = 8'hFB;
  localparam logic [7:0] cEop   = 8'hFD;
  localparam logic [7:0] cCarry = 8'hF7;
  localparam logic [7:0] cError = 8'hFE;
  localparam logic [7:0] cD5p6  = 8'hC5;
  localparam logic [7:0] cD16p2 = 8'h50;
  localparam logic [7:0] cD21p5 = 8'hB5;
  localparam logic [7:0] cD2p2  = 8'h42;

  localparam logic [1:0] cMinSets = 2'(pIdleMinSets);

  logic [2:0]  state, stateNxt;
  logic [2:0]  cfgIdx, cfgIdxNxt;
  logic [1:0]  mode, modeNxt;
  logic [15:0] cfgLatch, cfgLatchNxt;
  logic [1:0]  idleSets, idleSetsNxt;
  logic        sopPend, sopPendNxt;
  logic        rdValid;
  logic        txEnPrev;
  logic [7:0]  dataNxt;
  logic        kNxt;

  logic        nextEven;
  logic        txRise;
  logic        samplePt;
  logic [1:0]  xmitMode;
  logic [1:0]  effMode;
  logic        gapOk;
  logic        sopNow;
  logic        rdSel;

  // Ordered sets always start on even slots, so the idle K and config
  // index 0 positions are exactly the even slot boundaries between sets.
  assign nextEven = ~o_Even;
  assign txRise   = i_TxEN & ~txEnPrev;
  assign samplePt = (state == sIdleK) || ((state == sCfg) && (cfgIdx == 3'd0));
  assign xmitMode = (i2_Xmit == 2'b11) ? xIdle : i2_Xmit;
  assign effMode  = samplePt ? xmitMode : mode;
  assign gapOk    = (idleSets >= cMinSets);
  assign sopNow   = samplePt && (xmitMode == xData) && i_TxEN && (txRise || sopPend) && gapOk;
  // The first idle D after reset uses the reset disparity, not the encoder.
  assign rdSel    = rdValid & i_RdPos;

  // Next code-group and next state for every slot.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    stateNxt    = state;
    cfgIdxNxt   = cfgIdx;
    modeNxt     = mode;
    cfgLatchNxt = cfgLatch;
    idleSetsNxt = idleSets;
    dataNxt     = cK28p5;
    kNxt        = 1'b1;

    if (samplePt) begin
      modeNxt = xmitMode;
      if (xmitMode == xConfig) begin
        cfgLatchNxt = i16_ConfigReg;
        cfgIdxNxt   = 3'd1;
        stateNxt    = sCfg;
      end else if (sopNow) begin
        dataNxt  = cSop;
        stateNxt = sData;
      end else begin
        stateNxt = sIdleD;
      end
    end else begin
      case (state)
        sIdleD: begin
          dataNxt  = rdSel ? cD5p6 : cD16p2;
          kNxt     = 1'b0;
          stateNxt = sIdleK;
          if (idleSets < cMinSets) idleSetsNxt = idleSets + 2'd1;
        end
        sCfg: begin
          kNxt      = 1'b0;
          cfgIdxNxt = cfgIdx + 3'd1;
          case (cfgIdx)
            3'd1:    dataNxt = cD21p5;
            3'd2:    dataNxt = cfgLatch[7:0];
            3'd3:    dataNxt = cfgLatch[15:8];
            3'd4: begin
              dataNxt     = cK28p5;
              kNxt        = 1'b1;
              cfgLatchNxt = i16_ConfigReg;
            end
            3'd5:    dataNxt = cD2p2;
            3'd6:    dataNxt = cfgLatch[7:0];
            default: dataNxt = cfgLatch[15:8];
          endcase
        end
        sData: begin
          if (i_TxEN) begin
            dataNxt = i_TxER ? cError : i8_TxD;
            kNxt    = i_TxER;
          end else begin
            dataNxt     = cEop;
            stateNxt    = sEopR1;
            idleSetsNxt = 2'd0;
          end
        end
        sEopR1: begin
          dataNxt  = cCarry;
          // An /R/ on an even slot means /T/ was odd; pad so idles restart even.
          stateNxt = nextEven ? sEopR2 : sIdleK;
        end
        sEopR2: begin
          dataNxt  = cCarry;
          stateNxt = sIdleK;
        end
        default: begin
          stateNxt = sIdleD;
        end
      endcase
    end
  end

  // Track a TxEN rise that could not yet become /S/; a fall discards it.
  always_comb begin
    sopPendNxt = sopPend;
    if (!i_TxEN || sopNow || (effMode != xData)) begin
      sopPendNxt = 1'b0;
    end else if (txRise) begin
      sopPendNxt = 1'b1;
    end
  end

  // Register state, latches and the outgoing code-group.
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      state    <= sIdleD;
      cfgIdx   <= 3'd0;
      mode     <= xIdle;
      cfgLatch <= 16'h0000;
      idleSets <= cMinSets;
      sopPend  <= 1'b0;
      rdValid  <= 1'b0;
      // Treat TxEN as already high so a frame held across reset never starts.
      txEnPrev <= 1'b1;
      o8_Data  <= cK28p5;
      o_Kchar  <= 1'b1;
      o_Even   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // the same pre-edge values, independent of statement order.
      state    <= stateNxt;
      cfgIdx   <= cfgIdxNxt;
      mode     <= modeNxt;
      cfgLatch <= cfgLatchNxt;
      idleSets <= idleSetsNxt;
      sopPend  <= sopPendNxt;
      rdValid  <= 1'b1;
      txEnPrev <= i_TxEN;
      o8_Data  <= dataNxt;
      o_Kchar  <= kNxt;
      o_Even   <= ~o_Even;
    end
  end

endmodule
